hulohot_alu_seq: RTL and testbench
==================================

HULOHOT_ALU_SEQ -- requirements
Module: hulohot_alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port a  input  WIDTH  operand A, unsigned.
REQ-005 Port b  input  WIDTH  operand B, unsigned.
REQ-006 Port opcode  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 Port in_valid  input  1  a/b/opcode valid.
REQ-008 Port in_ready  output  1  block can accept an operation.
REQ-009 Port z  output  2*WIDTH  registered result.
REQ-010 Port carry  output  1  registered carry/borrow/overflow flag.
REQ-011 Port zero  output  1  registered flag; 1 when z == 0.
REQ-012 Port out_valid  output  1  z/carry/zero valid.
REQ-013 Port out_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE and 0 otherwise; out_valid SHALL be 1 in DONE and 0 otherwise.
REQ-016 An operation SHALL be accepted on a rising edge with in_valid=1 in IDLE; a, b, opcode are sampled only at that edge.
REQ-017 Non-MUL opcodes: IDLE->DONE on the accept edge; z/carry/zero update on that same edge (1-cycle latency).
REQ-018 MUL: IDLE->BUSY on accept; shift-add one multiplier bit per cycle; BUSY->DONE after exactly WIDTH BUSY cycles (out_valid high WIDTH+1 edges after accept).
REQ-019 DONE->IDLE on a rising edge with out_ready=1; while out_ready=0, z/carry/zero/out_valid SHALL hold unchanged.
REQ-020 No new operation SHALL be accepted on the DONE->IDLE edge; back-to-back throughput is one op per 2 cycles minimum.
REQ-021 ADD: z = zero-extended (WIDTH+1)-bit a+b; carry = bit WIDTH of the sum.
REQ-022 SUB: z = (WIDTH+1)-bit two's-complement a-b (zero-extended operands); carry = 1 iff a < b.
REQ-023 AND/OR/XOR: z low WIDTH bits = bitwise result, upper bits 0; carry = 0.
REQ-024 SHL/SHR: logical shift of a by b[clog2(WIDTH)-1:0], truncated to WIDTH bits, upper bits 0; carry = 0.
REQ-025 MUL: z = full 2*WIDTH-bit unsigned product; carry = 1 iff z[2*WIDTH-1:WIDTH] != 0.
REQ-026 zero SHALL be computed from the final z written in the same edge as z.
REQ-027 In BUSY, in_valid, a, b, opcode and out_ready SHALL be ignored; z/flags SHALL hold the previous result until DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, z=0, carry=0, zero=0, out_valid=0, in_ready=1, clearing internal MUL registers.
REQ-029 Reset asserted during BUSY or DONE SHALL abort the operation; no result is ever presented for it.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept an operation.

Verification (WIDTH=8)
REQ-031 ADD a=200 b=100, out_ready=1 -> next cycle out_valid=1, z=0x012C, carry=1, zero=0.
REQ-032 SUB a=5 b=7 -> z=0x01FE, carry=1; SUB a=7 b=7 -> z=0, zero=1, carry=0.
REQ-033 MUL a=15 b=17 -> in_ready=0 for 8 BUSY cycles, out_valid on 9th edge after accept, z=0x00FF, carry=0; MUL 255*255 -> z=0xFE01, carry=1.
REQ-034 AND a=0xF0 b=0x0F with out_ready=0 for 5 cycles -> z=0, zero=1 held steady, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 SHL a=0x81 b=9 -> shift 1, z=0x0002; SHR a=0x80 b=7 -> z=0x0001.
REQ-036 rst_n low 3 cycles into MUL -> out_valid=0, z=0, in_ready=1 asynchronously; subsequent ADD 1+1 -> z=2.

Source files
------------

// File: rtl/hulohot_alu_seq.sv
// Sequenced ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply,
// valid/ready handshake on both sides with results held until consumed.
//
// state  | meaning
// S_IDLE | ready for a new operation
// S_BUSY | multiply in progress, one multiplier bit per cycle
// S_DONE | result presented, waiting for out_ready
module hulohot_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               carry,
  output logic               zero,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_z;
  logic                 r_carry;
  logic                 r_zero;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [SW-1:0]        r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_shl;
  logic [WIDTH-1:0]     w_shr;
  logic [2*WIDTH-1:0]   w_alu_z;
  logic                 w_alu_c;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign z         = r_z;
  assign carry     = r_carry;
  assign zero      = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (opcode == OP_MUL) ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_shl  = a << b[SW-1:0];
  assign w_shr  = a >> b[SW-1:0];

  always_comb begin
    w_alu_z = '0;
    w_alu_c = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_alu_z = {{(WIDTH-1){1'b0}}, w_sum};
        w_alu_c = w_sum[WIDTH];
      end
      // borrow lands in the top bit of the (WIDTH+1)-bit difference
      OP_SUB: begin
        w_alu_z = {{(WIDTH-1){1'b0}}, w_diff};
        w_alu_c = w_diff[WIDTH];
      end
      OP_AND: w_alu_z = {{WIDTH{1'b0}}, a & b};
      OP_OR:  w_alu_z = {{WIDTH{1'b0}}, a | b};
      OP_XOR: w_alu_z = {{WIDTH{1'b0}}, a ^ b};
      OP_SHL: w_alu_z = {{WIDTH{1'b0}}, w_shl};
      OP_SHR: w_alu_z = {{WIDTH{1'b0}}, w_shr};
      default: ;
    endcase
  end

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z      <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= SW'(WIDTH - 1);
            end else begin
              r_z     <= w_alu_z;
              r_carry <= w_alu_c;
              r_zero  <= (w_alu_z == '0);
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_z     <= w_acc_nxt;
            r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_zero  <= (w_acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hulohot_alu_seq.sv
// Self-checking bench for hulohot_alu_seq (WIDTH=8): directed vectors,
// handshake/backpressure, reset abort and randomized ops against a reference.
module tb_hulohot_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   a, b;
  logic [2:0]     opcode;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] z;
  logic           carry;
  logic           zero;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  hulohot_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode),
    .in_valid(in_valid), .in_ready(in_ready), .z(z), .carry(carry),
    .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void ref_alu(input int op, input int aa, input int bb,
                                  output int rz, output int rc);
    rc = 0;
    case (op)
      0: begin rz = aa + bb; rc = (rz > 255) ? 1 : 0; end
      1: begin rz = (aa - bb) & 'h1FF; rc = (aa < bb) ? 1 : 0; end
      2: rz = aa & bb;
      3: rz = aa | bb;
      4: rz = aa ^ bb;
      5: rz = (aa << (bb % 8)) & 255;
      6: rz = aa >> (bb % 8);
      default: begin rz = aa * bb; rc = (rz > 255) ? 1 : 0; end
    endcase
  endfunction

  // Issue one op with out_ready=1; returns negedges from accept to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    a = aa; b = bb; opcode = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    n_checks++;
    if (z !== '0 || carry !== 1'b0 || zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_result: z=%h c=%b zero=%b, want 0 0 0", z, carry, zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [7:0]  as  [7] = '{8'd200, 8'd5, 8'd7, 8'h81, 8'h80, 8'd255, 8'd15};
    logic [7:0]  bs  [7] = '{8'd100, 8'd7, 8'd7, 8'd9, 8'd7, 8'd255, 8'd17};
    logic [15:0] ez  [7] = '{16'h012C, 16'h01FE, 16'h0000, 16'h0002, 16'h0001, 16'hFE01, 16'h00FF};
    logic        ec  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          el  [7] = '{1, 1, 1, 1, 1, 9, 9};
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      n_checks++;
      if (z !== ez[i] || carry !== ec[i] || zero !== (ez[i] == 16'h0)) begin
        n_errors++;
        $display("FAIL directed_%0d: z=%h c=%b zero=%b, want z=%h c=%b zero=%b",
                 i, z, carry, zero, ez[i], ec[i], ez[i] == 16'h0);
      end
      n_checks++;
      if (lat !== el[i]) begin
        n_errors++;
        $display("FAIL directed_lat_%0d: latency=%0d, want %0d", i, lat, el[i]);
      end
    end
  endtask

  task automatic test_mul_busy();
    int lat;
    run_op(3'd0, 8'd3, 8'd4, lat);
    @(negedge clk);
    a = 8'd15; b = 8'd17; opcode = 3'd7; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || z !== 16'd7) begin
        n_errors++;
        $display("FAIL mul_busy_%0d: in_ready=%b out_valid=%b z=%h, want 0 0 0007",
                 k, in_ready, out_valid, z);
      end
      a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || z !== 16'h00FF || carry !== 1'b0 || zero !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_done: out_valid=%b z=%h c=%b, want 1 00ff 0", out_valid, z, carry);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    a = 8'hF0; b = 8'h0F; opcode = 3'd2; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd1; b = 8'd1; opcode = 3'd0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== '0 || zero !== 1'b1 || carry !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b z=%h zero=%b, want 1 0 0000 1",
                 k, out_valid, in_ready, z, zero);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== '0) begin
      n_errors++;
      $display("FAIL release_no_accept: out_valid=%b in_ready=%b z=%h, want 0 1 0000",
               out_valid, in_ready, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat, c0, rz, rc;
    logic [7:0] aa, bb;
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      aa = 8'($urandom); bb = 8'($urandom);
      run_op(3'd0, aa, bb, lat);
      ref_alu(0, int'(aa), int'(bb), rz, rc);
      n_checks++;
      if (z !== rz[15:0] || carry !== rc[0] || lat !== 1) begin
        n_errors++;
        $display("FAIL b2b_%0d: z=%h c=%b lat=%0d, want %h %b 1", i, z, carry, lat, rz[15:0], rc[0]);
      end
    end
    n_checks++;
    if (cyc - c0 !== 12) begin
      n_errors++;
      $display("FAIL b2b_throughput: cycles=%0d, want 12", cyc - c0);
    end
  endtask

  task automatic test_random();
    int lat, rz, rc, op;
    logic [7:0] aa, bb;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 7));
      aa = 8'($urandom); bb = 8'($urandom);
      run_op(3'(op), aa, bb, lat);
      ref_alu(op, int'(aa), int'(bb), rz, rc);
      n_checks++;
      if (z !== rz[15:0] || carry !== rc[0] || zero !== (rz == 0) ||
          lat !== ((op == 7) ? 9 : 1)) begin
        n_errors++;
        $display("FAIL random_%0d op=%0d a=%0d b=%0d: z=%h c=%b zero=%b lat=%0d, want %h %b %b %0d",
                 i, op, aa, bb, z, carry, zero, lat, rz[15:0], rc[0], rz == 0, (op == 7) ? 9 : 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    run_op(3'd0, 8'd1, 8'd2, lat);
    @(negedge clk);
    a = 8'd200; b = 8'd200; opcode = 3'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== '0 || carry !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_async: out_valid=%b in_ready=%b z=%h c=%b, want 0 1 0000 0",
               out_valid, in_ready, z, carry);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a = 8'd1; b = 8'd1; opcode = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || z !== 16'd2 || carry !== 1'b0 || zero !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_then_add: out_valid=%b z=%h c=%b, want 1 0002 0", out_valid, z, carry);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_busy();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
